// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment display reader
package seg_pkg;
  localparam int DIGITS = 4;
  localparam int STABLE_DEFAULT = 16;
  // Active-low segment patterns for hex digits 0..F, bit order g..a
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low segment pattern to its hex value
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);
  // linear search over the pattern table; unknown patterns leave valid low
  always_comb begin
    value = '0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_PAT[i]) begin
        value = 4'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_reader.sv
// seg_reader: samples a multiplexed 4-digit display bus and rebuilds its value
module seg_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_DEFAULT
)
(
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [6:0]  SEG_N,
  input  logic [3:0]  DIG_N,
  output logic [15:0] VALUE,
  output logic        VALID,
  output logic [3:0]  ERR,
  output logic        BUS_ERR
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0] seg_s1, seg_s2;
  logic [DIGITS-1:0] dig_s1, dig_s2, dig_low, cap, bad, seen;
  logic [10:0] prev;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic eval, changed, one_low, many_low, pat_ok;
  logic [3:0] pat_val;
  logic [DIGITS*4-1:0] slots, slots_n;

  seg_pattern_decode u_dec (.pattern(seg_s2), .value(pat_val), .valid(pat_ok));

  assign changed  = {dig_s2, seg_s2} != prev;
  assign dig_low  = ~dig_s2;
  assign one_low  = |dig_low && ((dig_low & (dig_low - 1'b1)) == '0);
  assign many_low = |dig_low && !one_low;
  assign cap      = eval && one_low && pat_ok ? dig_low : '0;
  assign bad      = eval && one_low && !pat_ok ? dig_low : '0;

  // two-flop synchronizers; idle bus reads as all ones
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      dig_s1 <= '1;
      dig_s2 <= '1;
    end else begin
      seg_s1 <= SEG_N;
      seg_s2 <= seg_s1;
      dig_s1 <= DIG_N;
      dig_s2 <= dig_s1;
    end
  end

  // stability tracker state, counter and last synchronized bus value
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= WAIT;
      cnt   <= '0;
      prev  <= '1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= {dig_s2, seg_s2};
    end
  end

  // any bus change restarts settling; one evaluation when the count tops out, then hold
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    eval    = 1'b0;
    if (changed) begin
      state_n = SETTLE;
      cnt_n   = '0;
    end else if (state == SETTLE) begin
      eval    = cnt == CNT_MAX;
      state_n = eval ? HOLD : SETTLE;
      cnt_n   = eval ? cnt : cnt + 1'b1;
    end
  end

  // write the captured nibble into its digit slot
  always_comb begin
    slots_n = slots;
    for (int n = 0; n < DIGITS; n++)
      if (cap[n]) slots_n[n*4 +: 4] = pat_val;
  end

  // frame assembly; a capture coinciding with frame completion counts for the next frame
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      VALUE   <= '0;
      VALID   <= 1'b0;
      ERR     <= '0;
      BUS_ERR <= 1'b0;
      slots   <= '0;
      seen    <= '0;
    end else begin
      slots   <= slots_n;
      seen    <= (&seen ? '0 : seen) | cap;
      VALID   <= &seen;
      if (&seen) VALUE <= slots;
      ERR     <= ERR | bad;
      BUS_ERR <= BUS_ERR | (eval && many_low);
    end
  end
endmodule

// File: tb/tb_seg_reader.sv
// tb_seg_reader: randomized and directed checks of seg_reader against a behavioural model
module tb_seg_reader;
  localparam int SC = 16;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic [6:0]  SEG_N = '1;
  logic [3:0]  DIG_N = '1;
  logic [15:0] VALUE;
  logic        VALID;
  logic [3:0]  ERR;
  logic        BUS_ERR;

  always #5 CLOCK_50 = ~CLOCK_50;

  seg_reader #(.STABLE_CYCLES(SC)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .SEG_N(SEG_N), .DIG_N(DIG_N),
    .VALUE(VALUE), .VALID(VALID), .ERR(ERR), .BUS_ERR(BUS_ERR)
  );

  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int compared = 0;
  int mismatched = 0;
  int vcnt = 0;

  logic [10:0] m_s1, m_s2, m_last;
  int          m_run, m_caps;
  logic [15:0] m_slots, m_value;
  logic [3:0]  m_seen, m_err;
  logic        m_valid, m_bus;

  function automatic int decode(input logic [6:0] p);
    int r = -1;
    for (int i = 0; i < 16; i++) if (p == pat[i]) r = i;
    return r;
  endfunction

  function automatic logic [3:0] sel(input int n);
    logic [3:0] one = 4'b0001;
    return ~(one << n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bus value seen unchanged (after 2-cycle sync) for SC further cycles is evaluated once
  always @(posedge CLOCK_50) begin : model
    logic [10:0] v;
    logic [3:0] nseen;
    int d, idx;
    if (RESET) begin
      m_s1 = '1; m_s2 = '1; m_last = '1; m_run = 0;
      m_slots = '0; m_value = '0; m_seen = '0; m_err = '0; m_valid = 1'b0; m_bus = 1'b0;
    end else begin
      v = m_s2;
      if (v == m_last) begin
        if (m_run < 1000000) m_run++;
      end else m_run = 0;
      m_last = v;
      m_s2 = m_s1;
      m_s1 = {DIG_N, SEG_N};
      m_valid = (m_seen == 4'hf);
      if (m_valid) m_value = m_slots;
      nseen = m_valid ? 4'h0 : m_seen;
      if (m_run == SC) begin
        if ($countones(~v[10:7]) == 1) begin
          idx = 0;
          for (int n = 0; n < 4; n++) if (!v[7+n]) idx = n;
          d = decode(v[6:0]);
          if (d >= 0) begin
            m_slots[idx*4 +: 4] = 4'(d);
            nseen[idx] = 1'b1;
            m_caps++;
          end else m_err[idx] = 1'b1;
        end else if ($countones(~v[10:7]) > 1) m_bus = 1'b1;
      end
      m_seen = nseen;
    end
  end

  initial m_caps = 0;

  // per-cycle comparison against the model
  always @(negedge CLOCK_50) begin
    chk("VALUE", 32'(VALUE), 32'(m_value));
    chk("VALID", 32'(VALID), 32'(m_valid));
    chk("ERR", 32'(ERR), 32'(m_err));
    chk("BUS_ERR", 32'(BUS_ERR), 32'(m_bus));
    if (VALID === 1'b1) vcnt++;
  end

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    DIG_N = d;
    SEG_N = s;
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    int v0, c0;
    logic [3:0] d;
    logic [6:0] s;
    repeat (3) @(negedge CLOCK_50);
    #1;
    RESET = 1'b0;
    chk("rst_value", 32'(VALUE), 32'h0);
    chk("rst_valid", 32'(VALID), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    chk("rst_bus", 32'(BUS_ERR), 32'h0);

    v0 = vcnt;
    for (int n = 0; n < 4; n++) hold(sel(n), pat[n+1], 20);
    hold(4'hf, 7'h7f, 5);
    chk("frame_pulses", 32'(vcnt - v0), 32'd1);
    chk("frame_value", 32'(VALUE), 32'h4321);

    v0 = vcnt;
    hold(sel(2), 7'h7f, 20);
    hold(sel(0), pat[5], 20);
    hold(sel(1), pat[6], 20);
    hold(sel(3), pat[7], 20);
    hold(4'hf, 7'h7f, 5);
    chk("bad_err", 32'(ERR), 32'h4);
    chk("bad_no_valid", 32'(vcnt - v0), 32'd0);
    hold(sel(2), pat[8], 20);
    hold(4'hf, 7'h7f, 5);
    chk("bad_fixed_pulses", 32'(vcnt - v0), 32'd1);
    chk("bad_fixed_value", 32'(VALUE), 32'h7865);

    v0 = vcnt;
    c0 = m_caps;
    for (int i = 0; i < 12; i++) hold(sel(i % 4), pat[(i * 3) % 16], 10);
    hold(4'hf, 7'h7f, 5);
    chk("toggle_pulses", 32'(vcnt - v0), 32'd0);
    chk("toggle_caps", 32'(m_caps - c0), 32'd0);
    chk("toggle_value", 32'(VALUE), 32'h7865);

    hold(4'b0011, pat[9], 20);
    hold(4'hf, 7'h7f, 5);
    chk("bus_err", 32'(BUS_ERR), 32'h1);
    chk("bus_value", 32'(VALUE), 32'h7865);
    chk("bus_err_keep", 32'(ERR), 32'h4);

    hold(sel(0), pat[9], 20);
    hold(sel(1), pat[10], 20);
    hold(sel(2), pat[11], 20);
    hold(4'hf, 7'h7f, 5);
    pulse_reset();
    chk("mid_rst_value", 32'(VALUE), 32'h0);
    chk("mid_rst_err", 32'(ERR), 32'h0);
    chk("mid_rst_bus", 32'(BUS_ERR), 32'h0);
    chk("mid_rst_valid", 32'(VALID), 32'h0);
    v0 = vcnt;
    hold(sel(3), pat[12], 20);
    hold(4'hf, 7'h7f, 5);
    chk("partial_discard", 32'(vcnt - v0), 32'd0);
    for (int n = 0; n < 3; n++) hold(sel(n), pat[n+1], 20);
    hold(4'hf, 7'h7f, 5);
    chk("recapture_pulses", 32'(vcnt - v0), 32'd1);
    chk("recapture_value", 32'(VALUE), 32'hC321);

    v0 = vcnt;
    hold(sel(0), pat[1], 20);
    hold(sel(2), pat[2], 20);
    hold(sel(3), pat[3], 20);
    c0 = m_caps;
    hold(sel(1), pat[14], 1000);
    chk("dwell_caps", 32'(m_caps - c0), 32'd1);
    chk("dwell_pulses", 32'(vcnt - v0), 32'd1);
    chk("dwell_value", 32'(VALUE), 32'h32E1);
    hold(sel(0), pat[1], 20);
    hold(sel(2), pat[2], 20);
    hold(sel(3), pat[3], 20);
    hold(4'hf, 7'h7f, 5);
    chk("dwell_no_wrap", 32'(vcnt - v0), 32'd1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: d = 4'hf;
        1: d = 4'($urandom_range(0, 15));
        default: d = sel($urandom_range(0, 3));
      endcase
      s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pat[$urandom_range(0, 15)];
      hold(d, s, $urandom_range(3, 30));
    end
    hold(4'hf, 7'h7f, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, the number of consecutive unchanged synchronized cycles needed before a digit is captured.
REQ-002 SHALL have port CLOCK_50  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SEG_N  input  7  active-low segment bus; bit0=a … bit6=g; 0 = lit.
REQ-005 SHALL have port DIG_N  input  4  active-low digit enables of an external multiplexed 4-digit display; bit n low selects digit n.
REQ-006 SHALL have port VALUE  output  16  last complete frame; nibble n = digit n.
REQ-007 SHALL have port VALID  output  1  one-cycle pulse when VALUE updates.
REQ-008 SHALL have port ERR  output  4  sticky per digit: an unrecognized pattern was captured on that digit.
REQ-009 SHALL have port BUS_ERR  output  1  sticky: a stable state with more than one digit enable low occurred.

Function
REQ-010 SHALL pass SEG_N and DIG_N through a 2-flop synchronizer before any other use.
REQ-011 SHALL decode synchronized SEG_N (bits g..a) as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; any other pattern is invalid.
REQ-012 SHALL run the FSM WAIT -> SETTLE -> HOLD; WAIT/HOLD -> SETTLE on any change of synchronized {DIG_N,SEG_N}, with the stability counter cleared.
REQ-013 SHALL, in SETTLE, increment the counter each unchanged cycle and, on reaching STABLE_CYCLES-1, perform exactly one capture evaluation, then go to HOLD.
REQ-014 SHALL make no further capture in HOLD until the inputs change, so a long dwell gives one capture.
REQ-015 SHALL, on evaluation, do the following according to DIG_N:
- exactly one bit low, valid pattern: store the nibble in digit slot n and set seen[n];
- exactly one bit low, invalid pattern: set ERR[n] and leave slot n and seen[n] unchanged;
- all bits high (blank): nothing;
- two or more bits low: set BUS_ERR only.
REQ-016 SHALL, in the cycle after seen becomes 4'b1111, copy all four slots to VALUE, pulse VALID high for one cycle, and clear seen; the capture and the clear of seen in the same cycle SHALL count the new capture toward the next frame.
REQ-017 SHALL hold VALUE between frames; re-capturing a digit before the frame completes SHALL overwrite its slot.
REQ-018 SHALL keep a 5-bit counter width for the default parameter and SHALL NOT let it wrap; it saturates in HOLD.
REQ-019 SHALL clear ERR and BUS_ERR only by reset.

Reset
REQ-020 SHALL, on RESET assertion, asynchronously set: VALUE=16'h0000, VALID=0, ERR=4'b0000, BUS_ERR=0, slots=0, seen=0, counter=0, synchronizers=all ones, FSM=WAIT.
REQ-021 SHALL, on reset mid-operation, discard any partial frame; the first VALID after release requires all four digits to be captured anew.

Structure
REQ-022 SHALL place the 16 segment pattern constants, the digit count (4) and the STABLE_CYCLES default in shared package seg_pkg.
REQ-023 SHALL implement the pattern lookup as combinational sub-module seg_pattern_decode (in: 7-bit pattern; out: 4-bit value and 1-bit valid).

Verification
REQ-024 SHALL cover: digits 0..3 each driven stable for 20 cycles with patterns for 1,2,3,4 -> a single VALID pulse and VALUE=16'h4321.
REQ-025 SHALL cover: digit 2 driven with 7'b1111111 -> ERR=4'b0100, no VALID until digit 2 later shows a valid pattern.
REQ-026 SHALL cover: inputs toggled every 10 cycles (under STABLE_CYCLES) -> no captures and no VALID.
REQ-027 SHALL cover: DIG_N=4'b0011 held 20 cycles -> BUS_ERR=1, VALUE unchanged.
REQ-028 SHALL cover: RESET pulsed after 3 of 4 digits are captured -> outputs at reset values, and the first VALID occurs only after all 4 digits are recaptured.
REQ-029 SHALL cover: one digit held for 1000 cycles -> exactly one capture (seen bit set once), no counter wrap.
